// File: rtl/ysyx_22041211_ifu_pkg.sv
// Shared types and constants for the instruction fetch unit: FSM state encoding,
// bus response codes and the default reset PC.
package ysyx_22041211_ifu_pkg;

    localparam logic [31:0] IFU_RESET_PC = 32'h8000_0000;
    localparam logic [1:0]  RESP_OKAY    = 2'b00;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_AR      = 3'd1,
        ST_R       = 3'd2,
        ST_ISSUE   = 3'd3,
        ST_WAITNPC = 3'd4,
        ST_HALT    = 3'd5
    } ifu_state_e;

    // Instructions are word aligned; any set low bit in a next-PC is a fault.
    function automatic logic is_misaligned(input logic [1:0] lsb);
        return lsb != 2'b00;
    endfunction

endpackage

// File: rtl/ysyx_22041211_ifu_pc_reg.sv
// Architectural PC register: reloads RESET_PC on reset, loads npc_i when enabled,
// and flags a misaligned incoming next-PC.
module ysyx_22041211_ifu_pc_reg
    import ysyx_22041211_ifu_pkg::*;
#(
    parameter int                  ADDR_LEN = 32,
    parameter logic [ADDR_LEN-1:0] RESET_PC = IFU_RESET_PC
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                load_i,
    input  logic [ADDR_LEN-1:0] npc_i,
    output logic [ADDR_LEN-1:0] pc_o,
    output logic                misaligned_o
);

    logic [ADDR_LEN-1:0] pc_q;
    logic [ADDR_LEN-1:0] pc_d;

    // A misaligned target is still loaded so the faulting address stays visible.
    assign pc_d = load_i ? npc_i : pc_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o         = pc_q;
    assign misaligned_o = is_misaligned(npc_i[1:0]);

endmodule

// File: rtl/ysyx_22041211_ifu.sv
// Multi-cycle instruction fetch unit: one AR/R read per PC, presents {pc, inst}
// to the decoder, then waits for the next PC from execute.
module ysyx_22041211_ifu
    import ysyx_22041211_ifu_pkg::*;
#(
    parameter int                  ADDR_LEN = 32,
    parameter int                  DATA_LEN = 32,
    parameter logic [ADDR_LEN-1:0] RESET_PC = IFU_RESET_PC
) (
    input  logic                clk,
    input  logic                rst,
    output logic [ADDR_LEN-1:0] araddr_o,
    output logic                arvalid_o,
    input  logic                arready_i,
    input  logic [DATA_LEN-1:0] rdata_i,
    input  logic [1:0]          rresp_i,
    input  logic                rvalid_i,
    output logic                rready_o,
    output logic [ADDR_LEN-1:0] pc_o,
    output logic [DATA_LEN-1:0] inst_o,
    output logic                inst_valid_o,
    input  logic                inst_ready_i,
    input  logic                npc_valid_i,
    input  logic [ADDR_LEN-1:0] npc_i,
    output logic                fetch_err_o
);

    ifu_state_e          state_q;
    logic [DATA_LEN-1:0] inst_q;
    logic                err_q;
    logic                arvalid_q;
    logic                rready_q;
    logic                inst_valid_q;
    logic [ADDR_LEN-1:0] pc_q;
    logic                npc_misaligned;
    logic                pc_load;

    // The PC only moves when the FSM actually accepts a next-PC.
    assign pc_load = ((state_q == ST_ISSUE) && inst_ready_i && npc_valid_i) ||
                     ((state_q == ST_WAITNPC) && npc_valid_i);

    ysyx_22041211_ifu_pc_reg #(
        .ADDR_LEN (ADDR_LEN),
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk          (clk),
        .rst          (rst),
        .load_i       (pc_load),
        .npc_i        (npc_i),
        .pc_o         (pc_q),
        .misaligned_o (npc_misaligned)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            inst_q       <= '0;
            err_q        <= 1'b0;
            arvalid_q    <= 1'b0;
            rready_q     <= 1'b0;
            inst_valid_q <= 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    state_q   <= ST_AR;
                    arvalid_q <= 1'b1;
                end
                ST_AR: begin
                    if (arready_i) begin
                        state_q   <= ST_R;
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                    end
                end
                ST_R: begin
                    if (rvalid_i) begin
                        rready_q <= 1'b0;
                        if (rresp_i == RESP_OKAY) begin
                            inst_q       <= rdata_i;
                            inst_valid_q <= 1'b1;
                            state_q      <= ST_ISSUE;
                        end else begin
                            inst_q  <= '0;
                            err_q   <= 1'b1;
                            state_q <= ST_HALT;
                        end
                    end
                end
                ST_ISSUE: begin
                    // npc_valid_i only counts once the decoder has taken the instruction.
                    if (inst_ready_i) begin
                        inst_valid_q <= 1'b0;
                        if (npc_valid_i) begin
                            if (npc_misaligned) begin
                                err_q   <= 1'b1;
                                state_q <= ST_HALT;
                            end else begin
                                arvalid_q <= 1'b1;
                                state_q   <= ST_AR;
                            end
                        end else begin
                            state_q <= ST_WAITNPC;
                        end
                    end
                end
                ST_WAITNPC: begin
                    if (npc_valid_i) begin
                        if (npc_misaligned) begin
                            err_q   <= 1'b1;
                            state_q <= ST_HALT;
                        end else begin
                            arvalid_q <= 1'b1;
                            state_q   <= ST_AR;
                        end
                    end
                end
                ST_HALT: begin
                    state_q <= ST_HALT;
                end
                default: begin
                    state_q      <= ST_IDLE;
                    arvalid_q    <= 1'b0;
                    rready_q     <= 1'b0;
                    inst_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign araddr_o     = pc_q;
    assign pc_o         = pc_q;
    assign arvalid_o    = arvalid_q;
    assign rready_o     = rready_q;
    assign inst_o       = inst_q;
    assign inst_valid_o = inst_valid_q;
    assign fetch_err_o  = err_q;

endmodule

// File: tb/tb_ysyx_22041211_ifu.sv
// Scoreboard bench for the fetch unit: a randomised memory slave and decoder driver,
// with an expected-fetch/issue queue model checked by an independent monitor.
module tb_ysyx_22041211_ifu;

    localparam logic [31:0] RESET_PC = 32'h8000_0000;

    logic        clk;
    logic        rst;
    logic [31:0] araddr_o;
    logic        arvalid_o;
    logic        arready_i;
    logic [31:0] rdata_i;
    logic [1:0]  rresp_i;
    logic        rvalid_i;
    logic        rready_o;
    logic [31:0] pc_o;
    logic [31:0] inst_o;
    logic        inst_valid_o;
    logic        inst_ready_i;
    logic        npc_valid_i;
    logic [31:0] npc_i;
    logic        fetch_err_o;

    ysyx_22041211_ifu dut (
        .clk          (clk),
        .rst          (rst),
        .araddr_o     (araddr_o),
        .arvalid_o    (arvalid_o),
        .arready_i    (arready_i),
        .rdata_i      (rdata_i),
        .rresp_i      (rresp_i),
        .rvalid_i     (rvalid_i),
        .rready_o     (rready_o),
        .pc_o         (pc_o),
        .inst_o       (inst_o),
        .inst_valid_o (inst_valid_o),
        .inst_ready_i (inst_ready_i),
        .npc_valid_i  (npc_valid_i),
        .npc_i        (npc_i),
        .fetch_err_o  (fetch_err_o)
    );

    int checks   = 0;
    int failures = 0;

    // memory configuration
    int unsigned ar_delay = 0;
    int unsigned r_delay  = 0;
    bit          err_en   = 0;
    logic [31:0] err_addr = 32'h0;

    // decoder driver configuration
    int unsigned rdy_pct  = 100;
    int unsigned npc_pct  = 100;
    bit          npc_seq  = 1;

    // reference model state
    logic [31:0] fetch_q[$];
    logic [31:0] issue_q[$];
    logic [31:0] cur_pc   = RESET_PC;
    bit          m_ar, m_rr, m_iv, m_err, m_idle, m_wait;
    bit          chk_loop = 0;
    int          cyc      = 0;
    int          last_ar  = -1;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == RESET_PC) return 32'h0000_0413;
        return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tmo(input string nm);
        checks++;
        failures++;
        $display("FAIL %s: timed out, required event never seen at %0t", nm, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic accept(input logic [31:0] n);
        cur_pc = n;
        if (n[1:0] != 2'b00) begin
            m_err = 1'b1;
        end else begin
            m_ar = 1'b1;
            fetch_q.push_back(n);
            issue_q.push_back(n);
        end
    endtask

    task automatic drive_rand();
        int unsigned sel;
        inst_ready_i = ($urandom_range(99) < rdy_pct);
        npc_valid_i  = ($urandom_range(99) < npc_pct);
        sel = $urandom_range(9);
        if (npc_seq || sel < 6) npc_i = cur_pc + 32'd4;
        else if (sel < 9)       npc_i = $urandom & 32'hFFFF_FFFC;
        else                    npc_i = 32'hFFFF_FFFC;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        inst_ready_i = 1'b0;
        npc_valid_i  = 1'b0;
        tick();
        tick();
        @(negedge clk);
        chk("rst_arvalid", {31'b0, arvalid_o}, 32'd0);
        chk("rst_rready", {31'b0, rready_o}, 32'd0);
        chk("rst_inst_valid", {31'b0, inst_valid_o}, 32'd0);
        chk("rst_fetch_err", {31'b0, fetch_err_o}, 32'd0);
        chk("rst_pc", pc_o, RESET_PC);
        chk("rst_inst", inst_o, 32'd0);
        tick();
        rst = 1'b1;
    endtask

    // memory slave: AR/R with configurable wait states, garbage data when idle
    initial begin
        bit          s_rst, s_ar_hs, s_r_hs, r_pend;
        logic [31:0] s_addr, r_addr;
        int unsigned ar_cnt, r_cnt;
        arready_i = 1'b0;
        rvalid_i  = 1'b0;
        rdata_i   = 32'h0;
        rresp_i   = 2'b00;
        r_pend = 0; ar_cnt = 0; r_cnt = 0; r_addr = 32'h0;
        forever begin
            @(negedge clk);
            s_rst   = rst;
            s_ar_hs = arvalid_o && arready_i;
            s_r_hs  = rvalid_i && rready_o;
            s_addr  = araddr_o;
            @(posedge clk);
            #2;
            if (!s_rst || !rst) begin
                arready_i = 1'b0;
                rvalid_i  = 1'b0;
                r_pend = 0; ar_cnt = 0; r_cnt = 0;
            end else begin
                if (s_ar_hs) begin
                    arready_i = 1'b0;
                    r_pend = 1; r_cnt = 0; ar_cnt = 0;
                    r_addr = s_addr;
                end
                if (s_r_hs) rvalid_i = 1'b0;
                if (arvalid_o && !arready_i) begin
                    if (ar_cnt >= ar_delay) arready_i = 1'b1;
                    else ar_cnt++;
                end
                if (r_pend && !rvalid_i) begin
                    if (r_cnt >= r_delay) begin
                        rvalid_i = 1'b1;
                        rdata_i  = mem_word(r_addr);
                        rresp_i  = (err_en && r_addr == err_addr) ? 2'b10 : 2'b00;
                        r_pend   = 0;
                    end else begin
                        r_cnt++;
                    end
                end
            end
            if (!rvalid_i) begin
                rdata_i = $urandom;
                rresp_i = 2'($urandom_range(3));
            end
        end
    end

    // monitor: compares DUT outputs with the model, then advances the model on handshakes
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst) begin
                fetch_q.delete();
                issue_q.delete();
                fetch_q.push_back(RESET_PC);
                issue_q.push_back(RESET_PC);
                m_ar = 0; m_rr = 0; m_iv = 0; m_err = 0; m_idle = 1; m_wait = 0;
                cur_pc = RESET_PC;
                last_ar = -1;
            end else begin
                chk("arvalid", {31'b0, arvalid_o}, {31'b0, m_ar});
                chk("rready", {31'b0, rready_o}, {31'b0, m_rr});
                chk("inst_valid", {31'b0, inst_valid_o}, {31'b0, m_iv});
                chk("fetch_err", {31'b0, fetch_err_o}, {31'b0, m_err});
                if (arvalid_o) begin
                    if (fetch_q.size() == 0) begin
                        checks++; failures++;
                        $display("FAIL araddr_unexpected: arvalid with addr %h, required no fetch", araddr_o);
                    end else begin
                        chk("araddr", araddr_o, fetch_q[0]);
                    end
                end
                if (inst_valid_o) begin
                    if (issue_q.size() == 0) begin
                        checks++; failures++;
                        $display("FAIL issue_unexpected: inst_valid with pc %h, required none", pc_o);
                    end else begin
                        chk("issue_pc", pc_o, issue_q[0]);
                        chk("issue_inst", inst_o, mem_word(issue_q[0]));
                    end
                end
                if (m_idle) begin
                    m_ar = 1; m_idle = 0;
                end else begin
                    if (arvalid_o && arready_i) begin
                        if (chk_loop && last_ar >= 0) chk("loop_cycles", 32'(cyc - last_ar), 32'd3);
                        last_ar = cyc;
                        if (fetch_q.size() > 0) void'(fetch_q.pop_front());
                        m_ar = 0; m_rr = 1;
                    end
                    if (rvalid_i && rready_o) begin
                        m_rr = 0;
                        if (rresp_i == 2'b00) m_iv = 1;
                        else m_err = 1;
                    end
                    if (inst_valid_o && inst_ready_i) begin
                        if (issue_q.size() > 0) void'(issue_q.pop_front());
                        m_iv = 0;
                        if (npc_valid_i) accept(npc_i);
                        else m_wait = 1;
                    end else if (m_wait && npc_valid_i) begin
                        m_wait = 0;
                        accept(npc_i);
                    end
                end
            end
        end
    end

    initial begin
        bit seen;
        rst = 1'b0;
        inst_ready_i = 1'b0;
        npc_valid_i  = 1'b0;
        npc_i        = 32'h0;

        // zero-wait memory, always-ready decoder, sequential PCs
        do_reset();
        rdy_pct = 100; npc_pct = 100; npc_seq = 1; ar_delay = 0; r_delay = 0; chk_loop = 1;
        drive_rand();
        @(negedge clk);
        chk("idle_arvalid", {31'b0, arvalid_o}, 32'd0);
        for (int i = 1; i <= 24; i++) begin
            tick();
            drive_rand();
            @(negedge clk);
            if (i == 1) begin
                chk("first_arvalid", {31'b0, arvalid_o}, 32'd1);
                chk("first_araddr", araddr_o, RESET_PC);
            end
            if (i == 3) begin
                chk("first_inst_valid", {31'b0, inst_valid_o}, 32'd1);
                chk("first_inst", inst_o, 32'h0000_0413);
                chk("first_pc", pc_o, RESET_PC);
            end
            if (i == 4) chk("second_araddr", araddr_o, RESET_PC + 32'd4);
        end
        chk_loop = 0;

        // slow memory, then fully randomised traffic
        ar_delay = 4; r_delay = 3;
        for (int i = 0; i < 40; i++) begin tick(); drive_rand(); end
        npc_seq = 0;
        for (int i = 0; i < 400; i++) begin
            if (i % 20 == 0) begin
                ar_delay = $urandom_range(4);
                r_delay  = $urandom_range(4);
                rdy_pct  = ($urandom_range(1) == 0) ? 40 : 100;
                npc_pct  = ($urandom_range(1) == 0) ? 30 : 100;
            end
            tick();
            drive_rand();
        end

        // decoder stalls in ISSUE; npc pulses meanwhile must be ignored
        ar_delay = 0; r_delay = 0;
        inst_ready_i = 1'b0; npc_valid_i = 1'b0;
        tick();
        if (m_wait) begin
            npc_valid_i = 1'b1; npc_i = cur_pc + 32'd4;
            tick();
            npc_valid_i = 1'b0;
        end
        seen = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            if (inst_valid_o) seen = 1;
            else tick();
        end
        if (!seen) tmo("stall_issue");
        for (int k = 0; k < 5; k++) begin
            inst_ready_i = 1'b0;
            npc_valid_i  = (k % 2 == 0);
            npc_i        = 32'h8000_0200;
            @(negedge clk);
            chk("stall_inst_valid", {31'b0, inst_valid_o}, 32'd1);
            tick();
        end
        inst_ready_i = 1'b1; npc_valid_i = 1'b0;
        tick();
        inst_ready_i = 1'b0;
        @(negedge clk);
        chk("waitnpc_inst_valid", {31'b0, inst_valid_o}, 32'd0);
        chk("waitnpc_arvalid", {31'b0, arvalid_o}, 32'd0);
        tick();
        npc_valid_i = 1'b1; npc_i = 32'h8000_0100;
        tick();
        npc_valid_i = 1'b0;
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (inst_valid_o) seen = 1;
            else tick();
        end
        if (!seen) tmo("waitnpc_fetch");
        @(negedge clk);
        chk("waitnpc_pc", pc_o, 32'h8000_0100);
        chk("waitnpc_inst", inst_o, mem_word(32'h8000_0100));

        // bus error on the third fetch
        do_reset();
        err_en = 1; err_addr = 32'h8000_0008;
        rdy_pct = 100; npc_pct = 100; npc_seq = 1;
        seen = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            drive_rand();
            tick();
            if (fetch_err_o) seen = 1;
        end
        if (!seen) tmo("bus_err");
        @(negedge clk);
        chk("bus_err_inst", inst_o, 32'd0);
        chk("bus_err_flag", {31'b0, fetch_err_o}, 32'd1);
        for (int i = 0; i < 8; i++) begin
            tick();
            @(negedge clk);
            chk("halt_arvalid", {31'b0, arvalid_o}, 32'd0);
        end
        err_en = 0;

        // misaligned next PC
        do_reset();
        inst_ready_i = 1'b0; npc_valid_i = 1'b0;
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (inst_valid_o) seen = 1;
            else tick();
        end
        if (!seen) tmo("misalign_issue");
        inst_ready_i = 1'b1; npc_valid_i = 1'b1; npc_i = 32'h8000_0102;
        tick();
        inst_ready_i = 1'b0; npc_valid_i = 1'b0;
        @(negedge clk);
        chk("misalign_err", {31'b0, fetch_err_o}, 32'd1);
        chk("misalign_pc", pc_o, 32'h8000_0102);
        for (int i = 0; i < 5; i++) begin
            tick();
            @(negedge clk);
            chk("misalign_arvalid", {31'b0, arvalid_o}, 32'd0);
        end

        // reset while a read response is pending
        do_reset();
        r_delay = 3;
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (rready_o) seen = 1;
            else tick();
        end
        if (!seen) tmo("abort_rready");
        rst = 1'b0;
        tick();
        @(negedge clk);
        chk("abort_arvalid", {31'b0, arvalid_o}, 32'd0);
        chk("abort_rready", {31'b0, rready_o}, 32'd0);
        chk("abort_inst_valid", {31'b0, inst_valid_o}, 32'd0);
        chk("abort_pc", pc_o, RESET_PC);
        chk("abort_inst", inst_o, 32'd0);
        tick();
        rst = 1'b1;
        r_delay = 0;
        seen = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            tick();
            if (arvalid_o) seen = 1;
        end
        if (!seen) tmo("abort_restart");
        @(negedge clk);
        chk("abort_restart_addr", araddr_o, RESET_PC);
        tick();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
